// File: rtl/otter_int_ctrl_if.sv
// MCU-side IOBUS and interrupt handshake bundle for otter_int_ctrl.
interface otter_int_ctrl_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        INT;
    logic        INT_ACK;
    logic [31:0] CLAIM;

    modport master (
        output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, INT_ACK,
        input  RD_DATA, INT, CLAIM
    );

    modport slave (
        input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, INT_ACK,
        output RD_DATA, INT, CLAIM
    );
endinterface

// File: rtl/otter_int_ctrl.sv
// Memory-mapped interrupt controller for the OTTER MCU: synchronizes raw IRQs,
// latches pending bits per edge/level mode and drives a single INT request.
module otter_int_ctrl #(
    parameter int unsigned      N_CH      = 8,
    parameter logic [31:0]      BASE_ADDR = 32'h1100_0200,
    parameter logic [N_CH-1:0]  MODE_RST  = '1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] IRQ_IN,
    otter_int_ctrl_if.slave bus
);

    localparam int unsigned IDX_W    = 5;
    localparam logic [31:0] OFF_PEND = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK = 32'h0000_0004;
    localparam logic [31:0] OFF_MODE = 32'h0000_0008;
    localparam logic [31:0] OFF_ID   = 32'h0000_000C;
    localparam logic [31:0] OFF_EOI  = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              int_q, int_d;
    logic [31:0]       claim_q, claim_d;
    logic [N_CH-1:0]   sync1_q, sync1_d;
    logic [N_CH-1:0]   sync2_q, sync2_d;
    logic [N_CH-1:0]   prev_q, prev_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   mode_q, mode_d;

    logic [31:0]       off;
    logic [N_CH-1:0]   wdata;
    logic              wr_pend, wr_mask, wr_mode, wr_eoi;
    logic [N_CH-1:0]   rise, w1c, en_cur, en_nxt;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       id;
    logic [31:0]       rd_data_c;

    // Address decode; subtraction wraps addresses below BASE_ADDR out of range.
    always_comb begin
        off     = bus.IOBUS_ADDR - BASE_ADDR;
        wdata   = N_CH'(bus.IOBUS_OUT);
        wr_pend = bus.IOBUS_WR && (off == OFF_PEND);
        wr_mask = bus.IOBUS_WR && (off == OFF_MASK);
        wr_mode = bus.IOBUS_WR && (off == OFF_MODE);
        wr_eoi  = bus.IOBUS_WR && (off == OFF_EOI);
    end

    // Synchronizer, edge detect and register updates.
    always_comb begin
        sync1_d = IRQ_IN;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        mask_d  = wr_mask ? wdata : mask_q;
        mode_d  = wr_mode ? wdata : mode_q;
        w1c     = wr_pend ? wdata : '0;
        // Edge bits: set beats clear; level bits track the synchronized input.
        pend_d  = (mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & sync2_q);
        if (wr_mode) begin
            pend_d = pend_d & ~(~mode_q & wdata);
        end
        en_cur  = pend_q & mask_q;
        en_nxt  = pend_d & mask_d;
    end

    // Lowest-numbered enabled pending channel wins.
    always_comb begin
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (en_cur[i]) begin
                idx = IDX_W'(i);
            end
        end
        id = {|en_cur, 26'b0, idx};
    end

    always_comb begin
        rd_data_c = '0;
        case (off)
            OFF_PEND: rd_data_c = 32'(pend_q);
            OFF_MASK: rd_data_c = 32'(mask_q);
            OFF_MODE: rd_data_c = 32'(mode_q);
            OFF_ID:   rd_data_c = id;
            default:  rd_data_c = '0;
        endcase
    end

    // Request FSM; the mask/W1C drop path looks at next-cycle enables so INT
    // falls on the same edge as the write that removes the last source.
    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        case (state_q)
            IDLE: begin
                if (|en_cur) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.INT_ACK) begin
                    state_d = SERVICE;
                    claim_d = id;
                end else if (!(|en_nxt)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        int_d = (state_d == REQ);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            claim_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_RST;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            claim_q <= claim_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.RD_DATA = rd_data_c;
    assign bus.INT     = int_q;
    assign bus.CLAIM   = claim_q;

endmodule

// File: doc/otter_int_ctrl.md
OTTER_INT_CTRL -- requirements
Module: otter_int_ctrl

Interface
REQ-001 Parameter N_CH, default 8, number of interrupt channels; legal range 1..32.
REQ-002 Parameter BASE_ADDR, default 32'h1100_0200, IOBUS base address of the register block.
REQ-003 Parameter MODE_RST, default all-ones (N_CH bits), reset value of MODE; 1 = edge, 0 = level.
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-low.
REQ-006 IRQ_IN  in  N_CH  raw interrupt sources, asynchronous to CLK.
REQ-007 IOBUS_ADDR  in  32  MCU IOBUS address.
REQ-008 IOBUS_OUT  in  32  MCU write data.
REQ-009 IOBUS_WR  in  1  MCU write strobe, one cycle per write.
REQ-010 RD_DATA  out  32  read data for IOBUS_ADDR, combinational; routed to MCU IOBUS_IN.
REQ-011 INT  out  1  registered interrupt request to the MCU INT pin.
REQ-012 INT_ACK  in  1  one-cycle pulse from the MCU when it takes the interrupt.

Function
REQ-013 Register map (offset from BASE_ADDR): 0x0 PEND (R, write-1-to-clear), 0x4 MASK (RW, 1 = enabled), 0x8 MODE (RW), 0xC ID (R), 0x10 EOI (W, any data); bits at or above N_CH SHALL read 0 and ignore writes.
REQ-014 ID SHALL read {valid, 26'b0, idx[4:0]}: valid = |(PEND & MASK); idx = lowest set bit of PEND & MASK; idx = 0 when valid = 0.
REQ-015 Reads of unmapped offsets, or addresses outside BASE_ADDR..BASE_ADDR+0x13, SHALL return 0; writes to them SHALL be ignored.
REQ-016 Each IRQ_IN bit SHALL pass through a 2-flop synchronizer; edge detection SHALL compare sync stage 2 against one further registered copy.
REQ-017 Edge-mode channel: PEND bit set on a synchronized rising edge; cleared only by a W1C write to PEND.
REQ-018 Level-mode channel: PEND bit SHALL equal the synchronized level every cycle; W1C has no effect.
REQ-019 Same-cycle set and W1C on one edge-mode bit: set wins.
REQ-020 Changing MODE from level to edge SHALL clear that PEND bit; from edge to level, the bit follows the level from the next cycle.
REQ-021 FSM states: IDLE, REQ, SERVICE; INT = 1 only in REQ.
REQ-022 IDLE -> REQ when |(PEND & MASK) is true at a clock edge.
REQ-023 REQ -> SERVICE on INT_ACK; the ID at that edge is latched as CLAIM.
REQ-024 REQ -> IDLE if PEND & MASK becomes 0 (mask write or W1C) without INT_ACK; INT drops at the same edge.
REQ-025 SERVICE -> IDLE on an EOI write; a further pending channel re-raises INT one cycle later, via IDLE -> REQ.
REQ-026 INT_ACK outside REQ and EOI outside SERVICE SHALL be ignored.
REQ-027 Latency: IRQ_IN rising edge sampled at edge k -> PEND set at edge k+2 -> INT high at edge k+3, when the FSM is IDLE and the channel is masked-in.

Reset
REQ-028 While RST = 0 at a clock edge: PEND = 0, MASK = 0, MODE = MODE_RST, synchronizers and edge registers = 0, CLAIM = 0, state = IDLE, INT = 0.
REQ-029 Reset SHALL take precedence over all bus writes and events, including mid-REQ and mid-SERVICE.
REQ-030 An IRQ_IN bit held high through reset SHALL be seen as one rising edge after reset release.

Verification
REQ-031 MASK = 0x01, pulse IRQ_IN[0] for 1 cycle sampled at edge k -> PEND = 0x01 at k+2, INT = 1 at k+3; ID reads 0x8000_0000.
REQ-032 MASK = 0xFF, IRQ_IN[5] and IRQ_IN[2] rise together -> ID = 0x8000_0002; INT_ACK -> INT = 0; W1C 0x04, then EOI -> INT = 1 one cycle later, ID = 0x8000_0005.
REQ-033 MODE[3] = 0, MASK = 0x08, hold IRQ_IN[3] high -> INT = 1; W1C 0x08 -> PEND stays 0x08; drop IRQ_IN[3] -> PEND[3] = 0 two edges later.
REQ-034 INT = 1 in REQ, write MASK = 0 -> INT = 0 next edge, state IDLE, PEND unchanged.
REQ-035 Same cycle: W1C of bit 1 and a new synchronized edge on bit 1 -> PEND[1] = 1.
REQ-036 RST = 0 for one edge during SERVICE with PEND = 0xFF -> INT = 0, PEND = 0, MASK = 0, ID = 0, MODE = all-ones.
